// File: rtl/alu_div_16bit.sv
// alu_div_16bit: multi-cycle restoring divider beside the ALU, one quotient bit per clock.
// Signed mode is built only when ALU_DIV_SIGNED_EN is defined; otherwise is_signed is ignored.
module alu_div_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   input  logic             start_valid,
   output logic             start_ready,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             zero_flag,
   output logic             negative_flag,
   output logic             parity_flag,
   output logic             overflow_flag,
   output logic             div_zero_flag
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   state_t state_q, state_d;
   logic             accept;
   logic             last_step;
   logic [WIDTH-1:0] acc_q, dvs_q, rem_q, dvd_q;
   logic [CW-1:0]    cnt_q;
   logic             dz_q, ov_q;
   logic [WIDTH:0]   partial, diff;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic             dz_in, ov_in;
   logic [WIDTH-1:0] q_out, r_out;

   assign dz_in = (divisor == '0);

`ifdef ALU_DIV_SIGNED_EN
   logic a_neg, b_neg;
   logic q_neg_q, r_neg_q;

   assign a_neg = is_signed & dividend[WIDTH-1];
   assign b_neg = is_signed & divisor[WIDTH-1];
   assign a_abs = a_neg ? -dividend : dividend;
   assign b_abs = b_neg ? -divisor : divisor;
   assign ov_in = is_signed && (dividend == MOST_NEG) && (&divisor);

   // Remember the result signs; the iteration itself works on magnitudes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (accept) begin
         q_neg_q <= a_neg ^ b_neg;
         r_neg_q <= a_neg;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign a_abs = dividend;
   assign b_abs = divisor;
   assign ov_in = 1'b0;
`endif

   assign partial   = {rem_q, acc_q[WIDTH-1]};
   assign diff      = partial - {1'b0, dvs_q};
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      start_ready  = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               accept  = 1'b1;
               state_d = (dz_in || ov_in) ? FIX : BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (last_step) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, then one restoring step per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         dvd_q <= '0;
         cnt_q <= '0;
         dz_q  <= 1'b0;
         ov_q  <= 1'b0;
      end else if (accept) begin
         acc_q <= a_abs;
         dvs_q <= b_abs;
         rem_q <= '0;
         dvd_q <= dividend;
         cnt_q <= '0;
         dz_q  <= dz_in;
         ov_q  <= ov_in;
      end else if (state_q == BUSY) begin
         cnt_q <= cnt_q + 1'b1;
         if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            acc_q <= {acc_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= partial[WIDTH-1:0];
            acc_q <= {acc_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Final result selection: sign fix, then the two special cases override.
   always_comb begin
      q_out = acc_q;
      r_out = rem_q;
`ifdef ALU_DIV_SIGNED_EN
      if (q_neg_q) q_out = -acc_q;
      if (r_neg_q) r_out = -rem_q;
`endif
      if (dz_q) begin
         q_out = '1;
         r_out = dvd_q;
      end else if (ov_q) begin
         q_out = MOST_NEG;
         r_out = '0;
      end
   end

   // Output registers, written once in FIX and held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient      <= '0;
         remainder     <= '0;
         zero_flag     <= 1'b0;
         negative_flag <= 1'b0;
         parity_flag   <= 1'b0;
         overflow_flag <= 1'b0;
         div_zero_flag <= 1'b0;
      end else if (state_q == FIX) begin
         quotient      <= q_out;
         remainder     <= r_out;
         zero_flag     <= (q_out == '0);
         negative_flag <= q_out[WIDTH-1];
         parity_flag   <= ^q_out;
         overflow_flag <= ov_q & ~dz_q;
         div_zero_flag <= dz_q;
      end
   end

endmodule

// File: tb/tb_alu_div_16bit.sv
// tb_alu_div_16bit: directed self-checking bench for alu_div_16bit.
// Signed expectations follow ALU_DIV_SIGNED_EN; default build expects unsigned behaviour.
module tb_alu_div_16bit;
   logic        clk;
   logic        rst_n;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        is_signed;
   logic        start_valid;
   logic        start_ready;
   logic        busy;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        zero_flag;
   logic        negative_flag;
   logic        parity_flag;
   logic        overflow_flag;
   logic        div_zero_flag;

   int tests = 0;
   int fails = 0;
   int lat;

   alu_div_16bit #(.WIDTH(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dividend(dividend),
      .divisor(divisor),
      .is_signed(is_signed),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .busy(busy),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .quotient(quotient),
      .remainder(remainder),
      .zero_flag(zero_flag),
      .negative_flag(negative_flag),
      .parity_flag(parity_flag),
      .overflow_flag(overflow_flag),
      .div_zero_flag(div_zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request, take it on the next edge, then count edges until result_valid.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int n);
      dividend    = a;
      divisor     = b;
      is_signed   = s;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      dividend    = 16'hA5A5;
      divisor     = 16'h0001;
      is_signed   = ~s;
      n = 0;
      while (!result_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic ack;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      dividend     = '0;
      divisor      = '0;
      is_signed    = 1'b0;
      start_valid  = 1'b0;
      result_ready = 1'b0;
      #12;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_flags", {zero_flag, negative_flag, parity_flag, overflow_flag, div_zero_flag}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 100 / 7 unsigned
      run_op(16'd100, 16'd7, 1'b0, lat);
      chk("u100_7_latency", lat, 17);
      chk("u100_7_q", quotient, 16'h000E);
      chk("u100_7_r", remainder, 16'h0002);
      chk("u100_7_zero", zero_flag, 0);
      chk("u100_7_neg", negative_flag, 0);
      chk("u100_7_par", parity_flag, 1);
      chk("u100_7_ovdz", {overflow_flag, div_zero_flag}, 0);
      chk("u100_7_sready", start_ready, 0);
      ack();
      chk("u100_7_idle", start_ready, 1);

      // -100 / 7 with is_signed = 1
      run_op(16'hFF9C, 16'h0007, 1'b1, lat);
      chk("s100_7_latency", lat, 17);
`ifdef ALU_DIV_SIGNED_EN
      chk("s100_7_q", quotient, 16'hFFF2);
      chk("s100_7_r", remainder, 16'hFFFE);
      chk("s100_7_neg", negative_flag, 1);
      chk("s100_7_par", parity_flag, 1);
`else
      chk("s100_7_q", quotient, 16'h2484);
      chk("s100_7_r", remainder, 16'h0000);
      chk("s100_7_neg", negative_flag, 0);
      chk("s100_7_par", parity_flag, 0);
`endif
      chk("s100_7_ov", overflow_flag, 0);
      ack();

      // divide by zero
      run_op(16'h04D2, 16'h0000, 1'b0, lat);
      chk("dz_latency", lat, 1);
      chk("dz_q", quotient, 16'hFFFF);
      chk("dz_r", remainder, 16'h04D2);
      chk("dz_flag", div_zero_flag, 1);
      chk("dz_ov", overflow_flag, 0);
      chk("dz_neg_zero_par", {negative_flag, zero_flag, parity_flag}, 3'b100);
      ack();

      // most-negative / -1
      run_op(16'h8000, 16'hFFFF, 1'b1, lat);
`ifdef ALU_DIV_SIGNED_EN
      chk("ov_latency", lat, 1);
      chk("ov_q", quotient, 16'h8000);
      chk("ov_r", remainder, 16'h0000);
      chk("ov_flag", overflow_flag, 1);
      chk("ov_neg", negative_flag, 1);
`else
      chk("ov_latency", lat, 17);
      chk("ov_q", quotient, 16'h0000);
      chk("ov_r", remainder, 16'h8000);
      chk("ov_flag", overflow_flag, 0);
      chk("ov_zero", zero_flag, 1);
`endif
      chk("ov_dz", div_zero_flag, 0);
      ack();

      // backpressure with a stray request held during DONE
      run_op(16'd5, 16'd10, 1'b0, lat);
      chk("bp_latency", lat, 17);
      dividend    = 16'd9;
      divisor     = 16'd3;
      is_signed   = 1'b0;
      start_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_q", quotient, 16'h0000);
         chk("bp_hold_r", remainder, 16'h0005);
         chk("bp_hold_zero", zero_flag, 1);
         chk("bp_hold_valid", result_valid, 1);
         chk("bp_hold_sready", start_ready, 0);
      end
      ack();
      chk("bp_back_idle", start_ready, 1);
      chk("bp_valid_low", result_valid, 0);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("bp_next_accepted", busy, 1);
      lat = 0;
      while (!result_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_next_latency", lat, 17);
      chk("bp_next_q", quotient, 16'h0003);
      chk("bp_next_r", remainder, 16'h0000);
      ack();

      // reset during the 8th BUSY cycle
      dividend    = 16'h1234;
      divisor     = 16'h0003;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sready", start_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_q", quotient, 16'h0000);
      chk("mid_rst_r", remainder, 16'h0000);
      #1;
      rst_n = 1'b1;
      run_op(16'h0010, 16'h0004, 1'b0, lat);
      chk("post_rst_latency", lat, 17);
      chk("post_rst_q", quotient, 16'h0004);
      chk("post_rst_r", remainder, 16'h0000);
      ack();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
